// File: rtl/model_vector_dot_product.sv
// rtl/model_vector_dot_product.sv - streaming unsigned dot-product engine with START/READY handshake
// Optional sticky OVERFLOW output when MODEL_DOT_PRODUCT_OVERFLOW_EN is defined.
module model_vector_dot_product #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic                    DATA_A_OUT_ENABLE,
    output logic                    DATA_B_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
    ,
    output logic                    OVERFLOW
`endif
);

    typedef enum logic [1:0] {
        STARTER_STATE,
        INPUT_STATE,
        ENDER_STATE
    } state_t;

    state_t                  state, next_state;
    logic [DATA_SIZE-1:0]    acc, a_reg, b_reg;
    logic [CONTROL_SIZE-1:0] index, size_reg;
    logic                    flag_a, flag_b;
    logic                    cap_a, cap_b, pair_done, last_elem;
    logic [DATA_SIZE-1:0]    a_val, b_val, product, acc_next;

    // An operand arriving in the same cycle that completes the pair is used directly.
    assign cap_a     = (state == INPUT_STATE) && DATA_A_IN_ENABLE && !flag_a;
    assign cap_b     = (state == INPUT_STATE) && DATA_B_IN_ENABLE && !flag_b;
    assign a_val     = cap_a ? DATA_A_IN : a_reg;
    assign b_val     = cap_b ? DATA_B_IN : b_reg;
    assign pair_done = (state == INPUT_STATE) && (flag_a || cap_a) && (flag_b || cap_b);
    assign last_elem = (index == size_reg - CONTROL_SIZE'(1));

`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
    logic [2*DATA_SIZE-1:0] prod_full;
    logic [DATA_SIZE:0]     sum_full;
    logic                   ovf_flag;
    logic                   ovf_event;
    assign prod_full = {{DATA_SIZE{1'b0}}, a_val} * {{DATA_SIZE{1'b0}}, b_val};
    assign product   = prod_full[DATA_SIZE-1:0];
    assign sum_full  = {1'b0, acc} + {1'b0, product};
    assign acc_next  = sum_full[DATA_SIZE-1:0];
    assign ovf_event = (|prod_full[2*DATA_SIZE-1:DATA_SIZE]) || sum_full[DATA_SIZE];
`else
    assign product  = a_val * b_val;
    assign acc_next = acc + product;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= STARTER_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            STARTER_STATE: begin
                if (START) begin
                    next_state = (SIZE_IN != '0) ? INPUT_STATE : ENDER_STATE;
                end
            end
            INPUT_STATE: begin
                if (pair_done && last_elem) begin
                    next_state = ENDER_STATE;
                end
            end
            ENDER_STATE: next_state = STARTER_STATE;
            default:     next_state = STARTER_STATE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READY             <= 1'b0;
            DATA_A_OUT_ENABLE <= 1'b0;
            DATA_B_OUT_ENABLE <= 1'b0;
            DATA_OUT          <= '0;
            acc               <= '0;
            a_reg             <= '0;
            b_reg             <= '0;
            index             <= '0;
            size_reg          <= '0;
            flag_a            <= 1'b0;
            flag_b            <= 1'b0;
`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
            ovf_flag          <= 1'b0;
            OVERFLOW          <= 1'b0;
`endif
        end else begin
            READY             <= 1'b0;
            DATA_A_OUT_ENABLE <= 1'b0;
            DATA_B_OUT_ENABLE <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (START) begin
                        DATA_OUT <= '0;
                        acc      <= '0;
                        index    <= '0;
                        size_reg <= SIZE_IN;
                        flag_a   <= 1'b0;
                        flag_b   <= 1'b0;
`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
                        ovf_flag <= 1'b0;
`endif
                        if (SIZE_IN != '0) begin
                            DATA_A_OUT_ENABLE <= 1'b1;
                            DATA_B_OUT_ENABLE <= 1'b1;
                        end
                    end
                end
                INPUT_STATE: begin
                    if (cap_a) begin
                        a_reg  <= DATA_A_IN;
                        flag_a <= 1'b1;
                    end
                    if (cap_b) begin
                        b_reg  <= DATA_B_IN;
                        flag_b <= 1'b1;
                    end
                    if (pair_done) begin
                        acc    <= acc_next;
                        flag_a <= 1'b0;
                        flag_b <= 1'b0;
`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
                        ovf_flag <= ovf_flag || ovf_event;
`endif
                        if (!last_elem) begin
                            index             <= index + CONTROL_SIZE'(1);
                            DATA_A_OUT_ENABLE <= 1'b1;
                            DATA_B_OUT_ENABLE <= 1'b1;
                        end
                    end
                end
                ENDER_STATE: begin
                    DATA_OUT <= acc;
                    READY    <= 1'b1;
`ifdef MODEL_DOT_PRODUCT_OVERFLOW_EN
                    OVERFLOW <= ovf_flag;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/model_vector_dot_product.md
Name: model_vector_dot_product

Overview:
- Streaming dot-product engine for the NTM datapath. Sits directly upstream of the processing unit.
- Requests operand pairs element by element from vector memories and accumulates A[i]*B[i] over SIZE_IN elements.
- Returns the scalar result with the same START/READY control handshake the processing unit uses.

Parameters:
- DATA_SIZE, 64, width of operands, accumulator and result.
- CONTROL_SIZE, 64, width of the vector length and the internal element index.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-low.
- START  input  1  begin an operation; sampled only in STARTER_STATE.
- READY  output  1  one-cycle pulse; DATA_OUT is valid while it is high.
- SIZE_IN  input  CONTROL_SIZE  vector length N; latched on accepted START.
- DATA_A_IN_ENABLE  input  1  DATA_A_IN is valid this cycle.
- DATA_A_IN  input  DATA_SIZE  element of vector A.
- DATA_B_IN_ENABLE  input  1  DATA_B_IN is valid this cycle.
- DATA_B_IN  input  DATA_SIZE  element of vector B.
- DATA_A_OUT_ENABLE  output  1  one-cycle request for the next A element.
- DATA_B_OUT_ENABLE  output  1  one-cycle request for the next B element.
- DATA_OUT  output  DATA_SIZE  dot-product result; held until the next accepted START or reset.

Behaviour:
- Reset (RST=0, asynchronous): state=STARTER_STATE. READY, DATA_A_OUT_ENABLE, DATA_B_OUT_ENABLE, DATA_OUT, accumulator, index, latched size and both captured-flags are all 0.
- STARTER_STATE:
  - START=1 with SIZE_IN!=0: latch N; clear accumulator, index and flags; DATA_OUT<=0; pulse both request enables on the next cycle; go to INPUT_STATE.
  - START=1 with SIZE_IN=0: DATA_OUT<=0; go to ENDER_STATE; no request pulses.
- INPUT_STATE:
  - An A element is captured on DATA_A_IN_ENABLE=1 when flag_a=0, and flag_a is then set. B is captured the same way.
  - Further A or B enables while the matching flag is set are ignored; the first value is kept.
  - A and B may arrive in the same cycle or in any order, with any delay of at least 1 cycle after the request.
  - Pair complete: both flags set, or the final flag sets this cycle. Then accumulator <= accumulator + (A*B truncated to DATA_SIZE bits), with wrap-around modulo 2^DATA_SIZE, unsigned. Both flags clear.
  - Pair complete and index==N-1: go to ENDER_STATE.
  - Pair complete otherwise: index++, pulse both request enables on the next cycle.
- ENDER_STATE: DATA_OUT<=accumulator; READY<=1 for exactly one cycle; go to STARTER_STATE.
- Latency: READY rises one cycle after the edge that captures the last pair. For SIZE_IN=0, READY rises 2 cycles after START is sampled.
- START while in INPUT_STATE or ENDER_STATE is ignored.
- Request enables are never high while a pair is pending, and never high outside INPUT_STATE.
- Reset mid-operation aborts with no READY pulse. The next START restarts from element 0.
- Index and N compare at CONTROL_SIZE width. N=2^CONTROL_SIZE-1 is legal.

Optional Feature:
- Macro: MODEL_DOT_PRODUCT_OVERFLOW_EN.
- Defined:
  - Adds output OVERFLOW (1 bit), reset 0.
  - An internal sticky flag is set when any full 2*DATA_SIZE product has nonzero upper DATA_SIZE bits, or when any accumulation carries out of DATA_SIZE bits.
  - The flag is cleared on an accepted START.
  - OVERFLOW<=flag in ENDER_STATE, at the same time as DATA_OUT.
- Undefined: no port and no logic; results are identical.

Test Plan:
- SIZE_IN=3, A={1,2,3}, B={4,5,6}, both enables one cycle after each request -> 3 request pulses per vector, READY one cycle, DATA_OUT=32.
- Same vectors, each A arrives 2 cycles before its B, plus a duplicate A enable (value 99) before B -> DATA_OUT=32 (99 ignored), no extra requests.
- START with SIZE_IN=0 -> no request pulses; READY high exactly 2 cycles after START; DATA_OUT=0.
- DATA_SIZE=8, N=2, A={16,200}, B={16,1} -> DATA_OUT=200 (256 wraps to 0). With macro: OVERFLOW=1. Follow-up run A={1},B={1} -> DATA_OUT=1, OVERFLOW=0.
- RST low during element 2 of N=3 -> READY=0, DATA_OUT=0, request enables 0 immediately (asynchronous). Re-run of test 1 -> DATA_OUT=32.
- START held high throughout test 1 -> single operation; DATA_OUT=32; next operation begins only after the return to STARTER_STATE.
